digit_display_renderer: RTL and testbench



---
 rtl/digit_display_renderer.sv | 237 +++++++++++++++++++++++
 tb/tb_digit_display_renderer.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/digit_display_renderer.sv
// Multi-digit numeric overlay: double-dabble BCD conversion, frame-synchronous
// digit commit, and a 2-stage pixel pipeline rendering 8x16 glyphs in RGB222.
module digit_display_renderer #(
  parameter int unsigned NUM_DIGITS = 3,
  parameter int unsigned VALUE_W    = 10,
  parameter int unsigned X0         = 16,
  parameter int unsigned Y0         = 16,
  parameter logic [5:0]  FG         = 6'b000000,
  parameter logic [5:0]  BG         = 6'b111111,
  parameter bit          LZB        = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [VALUE_W-1:0] value,
  input  logic               value_valid,
  input  logic               frame_start,
  input  logic [9:0]         hcount,
  input  logic [9:0]         vcount,
  output logic [5:0]         pixel_color,
  output logic               pixel_active,
  output logic               busy,
  output logic               overflow
);

  localparam int unsigned BCD_W   = 4 * NUM_DIGITS;
  localparam int unsigned CNT_W   = (VALUE_W > 1) ? $clog2(VALUE_W) : 1;
  localparam int unsigned MAX_VAL = (10 ** NUM_DIGITS) - 1;
  localparam int unsigned X1      = X0 + 8 * NUM_DIGITS;
  localparam int unsigned Y1      = Y0 + 16;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} state_t;

  state_t             state;
  logic [VALUE_W-1:0] pend_val;
  logic [VALUE_W-1:0] conv_bin;
  logic               pending;
  logic               ovf_pend;
  logic               ovf_ready;
  logic               ready;
  logic [BCD_W-1:0]   conv_bcd;
  logic [BCD_W-1:0]   adj_bcd;
  logic [BCD_W-1:0]   ready_bcd;
  logic [BCD_W-1:0]   display_bcd;
  logic [CNT_W-1:0]   shift_cnt;

  logic [NUM_DIGITS-1:0] blank;
  logic                  lead;
  logic [9:0]            dx;
  logic [3:0]            dy;
  logic                  in_field;
  logic [3:0]            sel_digit;
  logic                  sel_blank;

  logic       s1_active;
  logic       s1_blank;
  logic [3:0] s1_digit;
  logic [2:0] s1_col;
  logic [3:0] s1_row;

  // Glyph ROM: digit 1 is a stem with flag and base; others are two-pixel-wide segments
  function automatic logic glyph_bit(input logic [3:0] d, input logic [2:0] c,
                                     input logic [3:0] r);
    logic [6:0] seg;
    logic top, mid, bot, upper, lower, lft, rgt, hz;
    top   = (r == 4'd1)  || (r == 4'd2);
    mid   = (r == 4'd7)  || (r == 4'd8);
    bot   = (r == 4'd13) || (r == 4'd14);
    upper = (r >= 4'd1)  && (r <= 4'd8);
    lower = (r >= 4'd7)  && (r <= 4'd14);
    lft   = (c <= 3'd1);
    rgt   = (c == 3'd5)  || (c == 3'd6);
    hz    = (c <= 3'd6);
    case (d)
      4'd0:    seg = 7'b1111110;
      4'd2:    seg = 7'b1101101;
      4'd3:    seg = 7'b1111001;
      4'd4:    seg = 7'b0110011;
      4'd5:    seg = 7'b1011011;
      4'd6:    seg = 7'b1011111;
      4'd7:    seg = 7'b1110000;
      4'd8:    seg = 7'b1111111;
      4'd9:    seg = 7'b1111011;
      default: seg = 7'b0000000;
    endcase
    if (d == 4'd1) begin
      return ((r >= 4'd1) && (r <= 4'd13) && ((c == 3'd3) || (c == 3'd4))) ||
             ((r == 4'd2) && (c == 3'd2)) ||
             ((r == 4'd14) && hz);
    end
    return (seg[6] && top && hz)   || (seg[5] && upper && rgt) ||
           (seg[4] && lower && rgt) || (seg[3] && bot && hz)   ||
           (seg[2] && lower && lft) || (seg[1] && upper && lft) ||
           (seg[0] && mid && hz);
  endfunction

  // Latest strobed value wins; LOAD consumes it unless a fresh strobe arrives
  always_ff @(posedge clk) begin
    if (reset) begin
      pending  <= 1'b0;
      pend_val <= '0;
    end else if (value_valid) begin
      pending  <= 1'b1;
      pend_val <= value;
    end else if (state == S_LOAD) begin
      pending  <= 1'b0;
    end
  end

  // Add-3 correction on every BCD nibble of 5 or more before each shift
  always_comb begin
    adj_bcd = conv_bcd;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (adj_bcd[4*i +: 4] >= 4'd5) adj_bcd[4*i +: 4] = adj_bcd[4*i +: 4] + 4'd3;
    end
  end

  // Converter FSM; result parks in the ready register until a frame start
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      conv_bin  <= '0;
      conv_bcd  <= '0;
      shift_cnt <= '0;
      ovf_pend  <= 1'b0;
      ovf_ready <= 1'b0;
      ready_bcd <= '0;
      ready     <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (pending || value_valid) begin
            state <= S_LOAD;
            busy  <= 1'b1;
          end
        end
        S_LOAD: begin
          conv_bin  <= pend_val;
          shift_cnt <= CNT_W'(VALUE_W - 1);
          if (64'(pend_val) > 64'(MAX_VAL)) begin
            conv_bcd <= {NUM_DIGITS{4'h9}};
            ovf_pend <= 1'b1;
            state    <= S_DONE;
          end else begin
            conv_bcd <= '0;
            ovf_pend <= 1'b0;
            state    <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          conv_bcd <= {adj_bcd[BCD_W-2:0], conv_bin[VALUE_W-1]};
          conv_bin <= conv_bin << 1;
          if (shift_cnt == '0) state <= S_DONE;
          else shift_cnt <= shift_cnt - 1'b1;
        end
        S_DONE: begin
          ready_bcd <= conv_bcd;
          ovf_ready <= ovf_pend;
          state     <= S_IDLE;
          busy      <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
      if (state == S_DONE) ready <= 1'b1;
      else if (frame_start) ready <= 1'b0;
    end
  end

  // Commit converted digits only at frame start so a frame never tears
  always_ff @(posedge clk) begin
    if (reset) begin
      display_bcd <= '0;
      overflow    <= 1'b0;
    end else if (frame_start && ready) begin
      display_bcd <= ready_bcd;
      overflow    <= ovf_ready;
    end
  end

  // Leading-zero mask, most significant digit first; last digit never blanked
  always_comb begin
    lead  = LZB;
    blank = '0;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      lead     = lead && (display_bcd[4*(int'(NUM_DIGITS)-1-i) +: 4] == 4'd0);
      blank[i] = lead && (i != int'(NUM_DIGITS) - 1);
    end
  end

  // Field decode and digit select for the current scan position
  always_comb begin
    dx        = hcount - 10'(X0);
    dy        = vcount[3:0] - 4'(Y0);
    in_field  = ({1'b0, hcount} >= 11'(X0)) && ({1'b0, hcount} < 11'(X1)) &&
                ({1'b0, vcount} >= 11'(Y0)) && ({1'b0, vcount} < 11'(Y1));
    sel_digit = 4'd0;
    sel_blank = 1'b0;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (dx[9:3] == 7'(i)) begin
        sel_digit = display_bcd[4*(int'(NUM_DIGITS)-1-i) +: 4];
        sel_blank = blank[i];
      end
    end
  end

  // Pixel stage 1: register decode results and glyph coordinates
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_active <= 1'b0;
      s1_blank  <= 1'b0;
      s1_digit  <= '0;
      s1_col    <= '0;
      s1_row    <= '0;
    end else begin
      s1_active <= in_field;
      s1_blank  <= sel_blank;
      s1_digit  <= sel_digit;
      s1_col    <= dx[2:0];
      s1_row    <= dy;
    end
  end

  // Pixel stage 2: glyph lookup and colour select
  always_ff @(posedge clk) begin
    if (reset) begin
      pixel_color  <= BG;
      pixel_active <= 1'b0;
    end else begin
      pixel_active <= s1_active;
      pixel_color  <= (s1_active && !s1_blank && glyph_bit(s1_digit, s1_col, s1_row)) ? FG : BG;
    end
  end

endmodule

// File: tb/tb_digit_display_renderer.sv
// Self-checking bench for digit_display_renderer: directed timing cases plus
// randomized values checked against a bitmap-painting reference model.
module tb_digit_display_renderer;

  localparam int         N   = 3;
  localparam int         VW  = 10;
  localparam int         X0  = 16;
  localparam int         Y0  = 16;
  localparam logic [5:0] FG  = 6'b000000;
  localparam logic [5:0] BG  = 6'b111111;
  localparam bit         LZB = 1'b1;

  logic          clk;
  logic          reset;
  logic [VW-1:0] value;
  logic          value_valid;
  logic          frame_start;
  logic [9:0]    hcount;
  logic [9:0]    vcount;
  logic [5:0]    pixel_color;
  logic          pixel_active;
  logic          busy;
  logic          overflow;

  int checks = 0;
  int errors = 0;

  bit    font [10][16][8];
  string segs [10];

  logic [6:0] exp_q [$];
  int         xq [$];
  int         yq [$];

  digit_display_renderer #(
    .NUM_DIGITS(N), .VALUE_W(VW), .X0(X0), .Y0(Y0), .FG(FG), .BG(BG), .LZB(LZB)
  ) dut (
    .clk(clk), .reset(reset), .value(value), .value_valid(value_valid),
    .frame_start(frame_start), .hcount(hcount), .vcount(vcount),
    .pixel_color(pixel_color), .pixel_active(pixel_active),
    .busy(busy), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rect(input int d, input int r0, input int r1, input int c0, input int c1);
    for (int r = r0; r <= r1; r++)
      for (int c = c0; c <= c1; c++) font[d][r][c] = 1'b1;
  endtask

  // Paint glyph bitmaps from segment letters; digit 1 from its explicit shape
  task automatic build_font();
    segs[0] = "abcdef"; segs[1] = "";      segs[2] = "abdeg";  segs[3] = "abcdg";
    segs[4] = "bcfg";   segs[5] = "acdfg"; segs[6] = "acdefg"; segs[7] = "abc";
    segs[8] = "abcdefg"; segs[9] = "abcdfg";
    for (int d = 0; d < 10; d++)
      for (int r = 0; r < 16; r++)
        for (int c = 0; c < 8; c++) font[d][r][c] = 1'b0;
    for (int d = 0; d < 10; d++) begin
      for (int k = 0; k < segs[d].len(); k++) begin
        case (segs[d][k])
          "a": rect(d, 1, 2, 0, 6);
          "b": rect(d, 1, 8, 5, 6);
          "c": rect(d, 7, 14, 5, 6);
          "d": rect(d, 13, 14, 0, 6);
          "e": rect(d, 7, 14, 0, 1);
          "f": rect(d, 1, 8, 0, 1);
          "g": rect(d, 7, 8, 0, 6);
          default: ;
        endcase
      end
    end
    rect(1, 1, 13, 3, 4);
    rect(1, 2, 2, 2, 2);
    rect(1, 14, 14, 0, 6);
  endtask

  // Expected {active, colour} for a pixel given the number on display
  function automatic logic [6:0] ref_pix(input int x, input int y, input int disp);
    int idx, col, row, weight, d;
    bit blank, on;
    if (x < X0 || x >= X0 + 8*N || y < Y0 || y >= Y0 + 16) return {1'b0, BG};
    idx = (x - X0) / 8;
    col = (x - X0) % 8;
    row = y - Y0;
    weight = 1;
    for (int k = 0; k < N - 1 - idx; k++) weight *= 10;
    d = (disp / weight) % 10;
    blank = LZB && (idx != N - 1) && (disp < weight);
    on = !blank && font[d][row][col];
    return {1'b1, on ? FG : BG};
  endfunction

  // Pipelined pixel probe: each drive is checked two clocks later
  task automatic px(input int x, input int y, input int disp);
    logic [6:0] e;
    int ex, ey;
    hcount = 10'(x);
    vcount = 10'(y);
    exp_q.push_back(ref_pix(x, y, disp));
    xq.push_back(x);
    yq.push_back(y);
    tick();
    if (exp_q.size() == 2) begin
      e = exp_q.pop_front(); ex = xq.pop_front(); ey = yq.pop_front();
      check($sformatf("active(%0d,%0d)", ex, ey), 32'(pixel_active), 32'(e[6]));
      check($sformatf("color(%0d,%0d)", ex, ey), 32'(pixel_color), 32'(e[5:0]));
    end
  endtask

  task automatic px_flush();
    logic [6:0] e;
    int ex, ey;
    tick();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); ex = xq.pop_front(); ey = yq.pop_front();
      check($sformatf("active(%0d,%0d)", ex, ey), 32'(pixel_active), 32'(e[6]));
      check($sformatf("color(%0d,%0d)", ex, ey), 32'(pixel_color), 32'(e[5:0]));
    end
  endtask

  task automatic scan_field(input int disp);
    for (int y = Y0 - 1; y <= Y0 + 16; y++)
      for (int x = X0 - 2; x <= X0 + 8*N + 1; x++) px(x, y, disp);
    px_flush();
  endtask

  task automatic scan_random(input int n, input int disp);
    for (int k = 0; k < n; k++) begin
      if (k % 2 == 0) px(X0 + int'($urandom_range(0, 8*N - 1)), Y0 + int'($urandom_range(0, 15)), disp);
      else px(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)), disp);
    end
    px_flush();
  endtask

  task automatic spot(input string tag, input int x, input int y, input logic [5:0] exp);
    hcount = 10'(x);
    vcount = 10'(y);
    tick();
    tick();
    check(tag, 32'(pixel_color), 32'(exp));
  endtask

  task automatic strobe(input int v);
    value = VW'(v);
    value_valid = 1'b1;
    tick();
    value_valid = 1'b0;
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  // Count busy cycles after a strobe, bounded
  task automatic busy_len(input string tag, input int exp);
    int cnt;
    cnt = 0;
    while (busy === 1'b1 && cnt < 200) begin
      cnt++;
      tick();
    end
    check(tag, 32'(cnt), 32'(exp));
  endtask

  task automatic convert_commit(input int v);
    int shown;
    shown = (v > 999) ? 999 : v;
    strobe(v);
    busy_len($sformatf("busy_len(%0d)", v), (v > 999) ? 2 : VW + 2);
    pulse_frame();
    check($sformatf("overflow(%0d)", v), 32'(overflow), 32'(v > 999));
    scan_random(60, shown);
  endtask

  initial begin
    build_font();
    reset = 1'b1; value = '0; value_valid = 1'b0; frame_start = 1'b0;
    hcount = '0; vcount = '0;
    repeat (3) tick();
    reset = 1'b0;

    check("reset_busy", 32'(busy), 32'(0));
    check("reset_overflow", 32'(overflow), 32'(0));
    check("reset_active", 32'(pixel_active), 32'(0));
    check("reset_color", 32'(pixel_color), 32'(BG));
    scan_field(0);
    spot("reset_lead_blank", X0 + 2, Y0 + 1, BG);

    // Reset during SHIFT aborts conversion and drops the pending value
    strobe(500);
    check("busy_after_strobe", 32'(busy), 32'(1));
    repeat (3) tick();
    check("busy_in_shift", 32'(busy), 32'(1));
    reset = 1'b1;
    tick();
    check("busy_after_abort", 32'(busy), 32'(0));
    reset = 1'b0;
    repeat (20) tick();
    check("busy_stays_idle", 32'(busy), 32'(0));
    pulse_frame();
    check("abort_overflow", 32'(overflow), 32'(0));
    scan_field(0);

    // Single digit 1 with fixed glyph points
    strobe(1);
    busy_len("busy_len(1)", VW + 2);
    pulse_frame();
    spot("one_stem", X0 + 19, Y0 + 5, 6'h00);
    spot("one_flag", X0 + 18, Y0 + 2, 6'h00);
    spot("one_left_clear", X0 + 17, Y0 + 5, 6'h3F);
    spot("one_col7_clear", X0 + 23, Y0 + 14, 6'h3F);
    for (int c = 0; c < 7; c++) spot($sformatf("one_base_c%0d", c), X0 + 16 + c, Y0 + 14, 6'h00);
    scan_field(1);

    // Overflow then recovery
    strobe(1023);
    busy_len("busy_len(1023)", 2);
    pulse_frame();
    check("ovf_set", 32'(overflow), 32'(1));
    scan_field(999);
    strobe(111);
    busy_len("busy_len(111)", VW + 2);
    pulse_frame();
    check("ovf_clear", 32'(overflow), 32'(0));
    scan_field(111);

    // Boundary values around 10^N-1
    convert_commit(999);
    convert_commit(1000);
    convert_commit(0);

    // Second strobe during busy: latest value wins
    strobe(205);
    tick(); tick();
    strobe(42);
    repeat (40) tick();
    check("busy_after_pair", 32'(busy), 32'(0));
    pulse_frame();
    scan_field(42);

    // Conversion finishing mid-frame stays hidden until next frame start
    strobe(777);
    busy_len("busy_len(777)", VW + 2);
    scan_field(42);
    pulse_frame();
    scan_field(777);

    // Frame start in the DONE cycle does not commit that result
    strobe(5);
    repeat (VW + 1) tick();
    check("busy_in_done", 32'(busy), 32'(1));
    pulse_frame();
    check("busy_after_done", 32'(busy), 32'(0));
    scan_random(60, 777);
    pulse_frame();
    scan_random(60, 5);

    // Frame start with a simultaneous strobe commits the older ready data
    strobe(360);
    busy_len("busy_len(360)", VW + 2);
    value = VW'(88);
    value_valid = 1'b1;
    frame_start = 1'b1;
    tick();
    value_valid = 1'b0;
    frame_start = 1'b0;
    scan_random(60, 360);
    repeat (20) tick();
    pulse_frame();
    scan_random(60, 88);

    // Pipeline alignment of pixel_active
    vcount = 10'(Y0 + 3);
    hcount = 10'(X0 - 1);
    tick();
    hcount = 10'(X0);
    tick();
    check("active_n1", 32'(pixel_active), 32'(0));
    tick();
    check("active_n2", 32'(pixel_active), 32'(1));

    // Randomized values
    for (int k = 0; k < 8; k++) convert_commit(int'($urandom_range(0, 1023)));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
